sc_nadder: RTL and testbench
============================

SC_NADDER -- requirements
Module: sc_nadder

Interface
REQ-001 The module SHALL have parameter NUM_INPUTS, default 4, giving the number of stochastic input channels; legal values are 2, 4, 8 and 16.
REQ-002 The module SHALL have parameter STREAM_LEN, default 256, giving the bitstream window length in valid cycles; legal range is 2..65535.
REQ-003 The module SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value.
REQ-004 The module SHALL derive SEL_W = clog2(NUM_INPUTS) and CNT_W = clog2(STREAM_LEN+1).
REQ-005 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-006 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port in_bits, input, NUM_INPUTS bits: one stochastic bit per channel; bit i is channel i.
REQ-009 Port in_valid, input, 1 bit: in_bits holds a valid sample this cycle.
REQ-010 Port mode, input, 1 bit: select source; 0 = LFSR pseudo-random, 1 = round-robin counter.
REQ-011 Port out_bit, output, 1 bit: scaled-sum stochastic output bit.
REQ-012 Port out_valid, output, 1 bit: out_bit is valid this cycle.
REQ-013 Port sum_count, output, CNT_W bits: number of 1s in out_bit over the last completed window.
REQ-014 Port count_valid, output, 1 bit: one-cycle pulse; sum_count was updated this cycle.

Function
REQ-015 The output SHALL represent (1/NUM_INPUTS) * sum of the channel probabilities, formed by selecting one channel per valid cycle.
REQ-016 The LFSR SHALL be a 16-bit Fibonacci LFSR: shift left, with new bit0 = b15^b13^b12^b10.
REQ-017 If SEED equals 0, the LFSR SHALL load 16'h0001 instead.
REQ-018 The round-robin counter SHALL be SEL_W bits wide, count 0,1,...,NUM_INPUTS-1, and wrap to 0.
REQ-019 The select value SHALL be LFSR[SEL_W-1:0] when mode=0 and the round-robin counter when mode=1, sampled in the same cycle as in_valid.
REQ-020 The LFSR and the round-robin counter SHALL both advance on every cycle with in_valid=1, regardless of mode, and SHALL hold otherwise.
REQ-021 A change of mode SHALL take effect on the next valid cycle, with no flush or restart.
REQ-022 Latency SHALL be 1 cycle: if in_valid=1 at cycle t, then at cycle t+1 out_valid=1 and out_bit=in_bits[select(t)].
REQ-023 If in_valid=0 at cycle t, then at cycle t+1 out_valid=0 and out_bit SHALL hold its previous value.
REQ-024 A window counter and a ones counter SHALL advance only on valid cycles; the ones counter increments when the selected bit is 1.
REQ-025 On the valid cycle that completes STREAM_LEN samples, the following SHALL happen at the next cycle:
- sum_count = ones count including that sample;
- count_valid = 1;
- both counters restart from 0, with the sample at that next cycle counted into the new window.
REQ-026 sum_count SHALL hold its value between windows.
REQ-027 count_valid SHALL never be high in two consecutive cycles unless every cycle is valid and STREAM_LEN windows align; with STREAM_LEN>=2 it SHALL be a single-cycle pulse.
REQ-028 Gaps in in_valid SHALL stretch a window in time without changing its sample count.

Reset
REQ-029 On rst=1 the following SHALL take the given values on the next edge, overriding in_valid:
- LFSR = SEED, or 1 if SEED is 0;
- round-robin counter = 0;
- window counter and ones counter = 0;
- out_bit = 0;
- out_valid = 0;
- sum_count = 0;
- count_valid = 0.
REQ-030 Reset asserted mid-window SHALL discard the partial window without producing a count_valid pulse.

Verification
REQ-031 With NUM_INPUTS=4, STREAM_LEN=256, mode=1, in_bits=4'b0001 and in_valid held at 1 -> out_bit repeats 1,0,0,0 starting at cycle 1; at cycle 256 count_valid=1 and sum_count=64.
REQ-032 With mode=0, SEED=16'hACE1 and in_bits=4'b1111 continuous -> out_bit is always 1; sum_count=256 every 256 cycles; the LFSR sequence matches the reference model.
REQ-033 With mode=1 and in_valid toggling 1,0,1,0 -> out_valid follows in_valid delayed by one cycle; select advances only on valid cycles; count_valid arrives after 256 valid samples, i.e. cycle 511.
REQ-034 With mode switched from 0 to 1 mid-stream -> the next valid sample uses the round-robin counter value, equal to (valid samples since reset) mod 4.
REQ-035 With rst asserted after 100 valid samples, then 256 more valid samples -> no pulse before the reset; a single count_valid 256 cycles after reset release, with sum_count counted from 0.
REQ-036 With NUM_INPUTS=2, SEED=0 and in_bits=2'b10 -> the LFSR starts at 1; sum_count equals the number of LFSR bit0 ones over the window, per the model.

Source files
------------

// File: rtl/sc_nadder.sv
// Stochastic scaled adder: picks one input channel per valid sample (pseudo-random
// or round-robin) and counts the ones of the resulting stream over fixed windows.
module sc_nadder #(
    parameter int          NUM_INPUTS = 4,
    parameter int          STREAM_LEN = 256,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         SEL_W      = $clog2(NUM_INPUTS),
    localparam int         CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] in_bits,
    input  logic                  in_valid,
    input  logic                  mode,
    output logic                  out_bit,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      sum_count,
    output logic                  count_valid
);

    // An all-zero seed would lock the LFSR, so it is replaced with 1.
    localparam logic [15:0]      LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [SEL_W-1:0] RR_LAST   = SEL_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(STREAM_LEN - 1);

    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [SEL_W-1:0] rr_cnt;
    logic [SEL_W-1:0] rr_next;
    logic [SEL_W-1:0] sel;
    logic             sel_bit;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] ones_next;
    logic             win_done;

    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        rr_next   = (rr_cnt == RR_LAST) ? '0 : rr_cnt + 1'b1;
        sel       = mode ? rr_cnt : lfsr[SEL_W-1:0];
        sel_bit   = in_bits[sel];
        ones_next = ones_cnt + CNT_W'(sel_bit);
        win_done  = (win_cnt == WIN_LAST);
    end

    // Both select sources step on every valid sample so a mode switch lands
    // mid-sequence rather than restarting either source.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= LFSR_INIT;
            rr_cnt <= '0;
        end else if (in_valid) begin
            lfsr   <= lfsr_next;
            rr_cnt <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bit <= sel_bit;
            end
        end
    end

    // The sample that completes a window is folded into sum_count directly,
    // so the new window starts empty on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            ones_cnt    <= '0;
            sum_count   <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (in_valid) begin
                if (win_done) begin
                    sum_count   <= ones_next;
                    count_valid <= 1'b1;
                    win_cnt     <= '0;
                    ones_cnt    <= '0;
                end else begin
                    win_cnt  <= win_cnt + 1'b1;
                    ones_cnt <= ones_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_nadder.sv
// Scoreboard bench for sc_nadder: default build plus a 2-input, zero-seed build.
module tb_sc_nadder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, mode;
    logic [3:0] in_bits;
    logic       out_bit, out_valid, count_valid;
    logic [8:0] sum_count;

    logic       rst2, in_valid2, mode2;
    logic [1:0] in_bits2;
    logic       out_bit2, out_valid2, count_valid2;
    logic [4:0] sum_count2;

    sc_nadder #(.NUM_INPUTS(4), .STREAM_LEN(256), .SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst), .in_bits(in_bits), .in_valid(in_valid), .mode(mode),
        .out_bit(out_bit), .out_valid(out_valid), .sum_count(sum_count),
        .count_valid(count_valid)
    );

    sc_nadder #(.NUM_INPUTS(2), .STREAM_LEN(16), .SEED(16'h0000)) u_dut2 (
        .clk(clk), .rst(rst2), .in_bits(in_bits2), .in_valid(in_valid2), .mode(mode2),
        .out_bit(out_bit2), .out_valid(out_valid2), .sum_count(sum_count2),
        .count_valid(count_valid2)
    );

    typedef struct packed {
        logic       ov;
        logic       ob;
        logic       cv;
        logic [8:0] sc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_rr, m_win, m_ones, m_sum;
    logic        m_out;
    int          since_rst, cv_cnt, first_cv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // One cycle: compare the previous cycle's prediction, then drive and predict.
    task automatic step(input logic r, input logic v, input logic [3:0] b, input logic m);
        exp_t e;
        int   sel;
        logic bitv;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", 32'(out_valid), 32'(e.ov));
            check("out_bit", 32'(out_bit), 32'(e.ob));
            check("count_valid", 32'(count_valid), 32'(e.cv));
            check("sum_count", 32'(sum_count), 32'(e.sc));
            if (count_valid === 1'b1) begin
                cv_cnt++;
                if (first_cv < 0) first_cv = since_rst;
            end
        end
        rst      = r;
        in_valid = v;
        in_bits  = b;
        mode     = m;
        e = '0;
        if (r) begin
            m_lfsr = 16'hACE1;
            m_rr = 0; m_win = 0; m_ones = 0; m_sum = 0;
            m_out = 1'b0;
            since_rst = 0; cv_cnt = 0; first_cv = -1;
        end else begin
            if (v) begin
                sel   = m ? m_rr : int'(m_lfsr[1:0]);
                bitv  = b[sel];
                m_out = bitv;
                if (m_win == 255) begin
                    m_sum  = m_ones + int'(bitv);
                    e.cv   = 1'b1;
                    m_win  = 0;
                    m_ones = 0;
                end else begin
                    m_win++;
                    m_ones += int'(bitv);
                end
                m_lfsr = lfsr_adv(m_lfsr);
                m_rr   = (m_rr + 1) % 4;
            end
            e.ov = v;
            since_rst++;
        end
        e.ob = m_out;
        e.sc = 9'(m_sum);
        exp_q.push_back(e);
    endtask

    initial begin
        logic [15:0] l;
        int          ones;
        logic        eb;

        rst = 1'b1; in_valid = 1'b0; in_bits = '0; mode = 1'b0;
        rst2 = 1'b1; in_valid2 = 1'b0; in_bits2 = '0; mode2 = 1'b0;
        since_rst = 0; cv_cnt = 0; first_cv = -1;

        step(1, 0, 4'h0, 0);
        step(1, 0, 4'h0, 0);

        // Round-robin on a single active channel: quarter density.
        for (int i = 0; i < 260; i++) step(0, 1, 4'b0001, 1);
        step(0, 0, 4'h0, 1);
        check("rr_first_cv_cycle", 32'(first_cv), 32'd256);
        check("rr_cv_pulses", 32'(cv_cnt), 32'd1);
        check("rr_sum", 32'(sum_count), 32'd64);

        // Pseudo-random select with all channels high.
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 514; i++) step(0, 1, 4'hF, 0);
        step(0, 0, 4'h0, 0);
        check("ones_cv_pulses", 32'(cv_cnt), 32'd2);
        check("ones_sum", 32'(sum_count), 32'd256);

        // Alternating valid stretches the window to 511 cycles.
        step(1, 0, 4'h0, 1);
        for (int i = 0; i < 520; i++) step(0, (i % 2) == 0, 4'($urandom), 1);
        step(0, 0, 4'h0, 1);
        check("gap_first_cv_cycle", 32'(first_cv), 32'd511);

        // Mode switch after 37 samples picks up the round-robin at 37 mod 4.
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 37; i++) step(0, 1, 4'($urandom), 0);
        step(0, 1, 4'b0010, 1);
        step(0, 0, 4'h0, 1);
        check("switch_rr1_bit", 32'(out_bit), 32'd1);
        step(0, 1, 4'b0100, 1);
        step(0, 0, 4'h0, 1);
        check("switch_rr2_bit", 32'(out_bit), 32'd1);

        // Reset in mid-window discards the partial count.
        step(1, 0, 4'h0, 1);
        for (int i = 0; i < 100; i++) step(0, 1, 4'($urandom), 1);
        step(0, 0, 4'h0, 1);
        check("pre_reset_pulses", 32'(cv_cnt), 32'd0);
        step(1, 0, 4'h0, 1);
        for (int i = 0; i < 260; i++) step(0, 1, 4'($urandom), 1);
        step(0, 0, 4'h0, 1);
        check("post_reset_pulses", 32'(cv_cnt), 32'd1);
        check("post_reset_cv_cycle", 32'(first_cv), 32'd256);

        // Random mix of valid, mode, data and occasional reset.
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 900; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom), 1'($urandom));
        step(0, 0, 4'h0, 0);
        step(0, 0, 4'h0, 0);

        // Two channels, zero seed: output follows LFSR bit0 from state 1.
        @(negedge clk);
        rst2 = 1'b1; in_valid2 = 1'b0;
        @(negedge clk);
        check("n2_reset_out_valid", 32'(out_valid2), 32'd0);
        check("n2_reset_sum", 32'(sum_count2), 32'd0);
        rst2 = 1'b0; in_valid2 = 1'b1; in_bits2 = 2'b10; mode2 = 1'b0;
        l = 16'h0001;
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            eb = l[0];
            ones += int'(eb);
            l = lfsr_adv(l);
            @(negedge clk);
            if (k == 15) in_valid2 = 1'b0;
            check("n2_out_bit", 32'(out_bit2), 32'(eb));
            check("n2_count_valid", 32'(count_valid2), (k == 15) ? 32'd1 : 32'd0);
        end
        check("n2_sum", 32'(sum_count2), 32'(ones));
        @(negedge clk);
        check("n2_cv_single", 32'(count_valid2), 32'd0);
        check("n2_sum_hold", 32'(sum_count2), 32'(ones));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
